// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions: 8b/10b control symbols and the receive link FSM encodings.
package pcie_phy_pkg;

  typedef logic [7:0] sym_t;

  localparam sym_t COM = 8'hBC;  // K28.5 comma
  localparam sym_t IDL = 8'h7C;  // idle fill

  localparam logic [1:0] ST_SEARCH = 2'b00;
  localparam logic [1:0] ST_SYNC   = 2'b01;
  localparam logic [1:0] ST_ACTIVE = 2'b10;

  // Fill symbols carry no payload and are never forwarded.
  function automatic logic is_fill(input sym_t b);
    return (b == COM) || (b == IDL);
  endfunction

endpackage

// File: rtl/rx_link_ctrl.sv
// Receive link controller: COM-run lock acquisition, payload forwarding with fill
// stripping, idle-gap loss of lock and a wrapping forwarded-byte counter.
module rx_link_ctrl
  import pcie_phy_pkg::*;
#(
  parameter int SYNC_COUNT  = 4,
  parameter int LOSS_CYCLES = 8
) (
  input  logic        clk4f,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        retrain,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        active,
  output logic [1:0]  state,
  output logic [15:0] byte_count
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_CYCLES - 1);

  logic [3:0] com_cnt, com_cnt_d;
  logic [7:0] gap_cnt, gap_cnt_d;
  logic [1:0] state_d;
  logic       fwd;
  logic       is_com;

  assign is_com = in_valid && (in_byte == COM);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d   = state;
    com_cnt_d = com_cnt;
    gap_cnt_d = gap_cnt;
    fwd       = 1'b0;

    if (retrain) begin
      state_d   = ST_SEARCH;
      com_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      case (state)
        ST_SEARCH: begin
          gap_cnt_d = '0;
          if (is_com) begin
            com_cnt_d = 4'd1;
            state_d   = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (in_valid) begin
            if (!is_com) begin
              com_cnt_d = '0;
              state_d   = ST_SEARCH;
            end else if (com_cnt == SYNC_LAST) begin
              com_cnt_d = '0;
              gap_cnt_d = '0;
              state_d   = ST_ACTIVE;
            end else begin
              com_cnt_d = com_cnt + 4'd1;
            end
          end
        end
        ST_ACTIVE: begin
          if (in_valid) begin
            gap_cnt_d = '0;
            fwd       = !is_fill(in_byte);
          end else if (gap_cnt == LOSS_LAST) begin
            // The LOSS_CYCLES-th consecutive idle cycle drops the link.
            gap_cnt_d = '0;
            state_d   = ST_SEARCH;
          end else begin
            gap_cnt_d = gap_cnt + 8'd1;
          end
        end
        default: begin
          state_d   = ST_SEARCH;
          com_cnt_d = '0;
          gap_cnt_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk4f) begin
    if (reset) begin
      state      <= ST_SEARCH;
      active     <= 1'b0;
      com_cnt    <= '0;
      gap_cnt    <= '0;
      out_valid  <= 1'b0;
      out_byte   <= 8'h00;
      byte_count <= 16'h0000;
    end else begin
      state     <= state_d;
      active    <= (state_d == ST_ACTIVE);
      com_cnt   <= com_cnt_d;
      gap_cnt   <= gap_cnt_d;
      out_valid <= fwd;
      if (fwd) begin
        out_byte   <= in_byte;
        byte_count <= byte_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Bench for rx_link_ctrl: table of per-cycle vectors with expected state/count,
// forwarded bytes tracked through a scoreboard queue.
module tb_rx_link_ctrl;
  import pcie_phy_pkg::*;

  logic        clk4f = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        retrain;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        active;
  logic [1:0]  state;
  logic [15:0] byte_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        r;
    logic [1:0]  es;
    logic        ef;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];

  rx_link_ctrl #(.SYNC_COUNT(4), .LOSS_CYCLES(8)) dut (
    .clk4f(clk4f), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .retrain(retrain), .out_byte(out_byte), .out_valid(out_valid),
    .active(active), .state(state), .byte_count(byte_count)
  );

  always #5 clk4f = ~clk4f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every out_valid pulse must match the oldest byte the bench expects forwarded.
  always @(negedge clk4f) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_byte), 32'hFFFF_FFFF);
      end else begin
        check("out_byte", 32'(out_byte), 32'(sb.pop_front()));
      end
    end
  end

  task automatic step(input logic [7:0] b, input logic v, input logic r,
                      input logic [1:0] es, input logic ef, input logic [15:0] ec,
                      input logic chk, input string name);
    in_byte  = b;
    in_valid = v;
    retrain  = r;
    if (ef) sb.push_back(b);
    @(posedge clk4f);
    #1;
    if (chk) begin
      check({name, "_state"}, 32'(state), 32'(es));
      check({name, "_active"}, 32'(active), 32'(es == ST_ACTIVE));
      check({name, "_count"}, 32'(byte_count), 32'(ec));
    end
  endtask

  function automatic void add(input logic [7:0] b, input logic v, input logic r,
                              input logic [1:0] es, input logic ef, input logic [15:0] ec);
    vec_t t;
    t.b = b; t.v = v; t.r = r; t.es = es; t.ef = ef; t.ec = ec;
    vecs.push_back(t);
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      in_byte  = 8'($urandom);
      in_valid = 1'b1;
      retrain  = 1'b0;
      @(posedge clk4f);
      #1;
      check("rst_state", 32'(state), 32'(ST_SEARCH));
      check("rst_active", 32'(active), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_byte", 32'(out_byte), 32'h00);
      check("rst_count", 32'(byte_count), 32'd0);
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] d;

    // Lock
    add(COM, 1, 0, ST_SYNC, 0, 0);
    add(COM, 1, 0, ST_SYNC, 0, 0);
    add(COM, 1, 0, ST_SYNC, 0, 0);
    add(COM, 1, 0, ST_ACTIVE, 0, 0);
    // Forwarding with fill stripping
    add(8'h11, 1, 0, ST_ACTIVE, 1, 1);
    add(COM, 1, 0, ST_ACTIVE, 0, 1);
    add(IDL, 1, 0, ST_ACTIVE, 0, 1);
    add(8'h22, 1, 0, ST_ACTIVE, 1, 2);
    add(8'h33, 1, 0, ST_ACTIVE, 1, 3);
    // 7 idle cycles keep lock
    for (int i = 0; i < 7; i++) add(8'hA5, 0, 0, ST_ACTIVE, 0, 3);
    add(8'h55, 1, 0, ST_ACTIVE, 1, 4);
    // 8 idle cycles drop lock
    for (int i = 0; i < 7; i++) add(8'h5A, 0, 0, ST_ACTIVE, 0, 4);
    add(8'h5A, 0, 0, ST_SEARCH, 0, 4);
    // Broken sync, then a bubble inside a COM run
    add(COM, 1, 0, ST_SYNC, 0, 4);
    add(COM, 1, 0, ST_SYNC, 0, 4);
    add(COM, 1, 0, ST_SYNC, 0, 4);
    add(8'h55, 1, 0, ST_SEARCH, 0, 4);
    add(COM, 1, 0, ST_SYNC, 0, 4);
    add(COM, 1, 0, ST_SYNC, 0, 4);
    add(8'h00, 0, 0, ST_SYNC, 0, 4);
    add(COM, 1, 0, ST_SYNC, 0, 4);
    add(COM, 1, 0, ST_ACTIVE, 0, 4);
    // Retrain coincident with a payload byte
    add(8'h44, 1, 1, ST_SEARCH, 0, 4);
    add(8'h66, 1, 0, ST_SEARCH, 0, 4);
    // Retrain while idle in SEARCH stays put
    add(COM, 1, 1, ST_SEARCH, 0, 4);

    in_byte  = 8'h00;
    in_valid = 1'b0;
    retrain  = 1'b0;
    reset    = 1'b1;
    @(negedge clk4f);
    do_reset(3);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].b, vecs[i].v, vecs[i].r, vecs[i].es, vecs[i].ef, vecs[i].ec, 1'b1,
           $sformatf("vec%0d", i));
    step(8'h00, 0, 0, ST_SEARCH, 0, 4, 1'b1, "post_vec");
    check("sb_empty_vec", 32'(sb.size()), 32'd0);

    // Counter wrap from a clean reset
    do_reset(1);
    for (int i = 0; i < 4; i++)
      step(COM, 1, 0, (i == 3) ? ST_ACTIVE : ST_SYNC, 0, 0, 1'b1, "relock");
    for (int i = 1; i <= 65537; i++) begin
      d = 8'($urandom);
      if (is_fill(d)) d = 8'h01;
      step(d, 1, 0, ST_ACTIVE, 1, 16'(i), 1'b0, "wrap");
      if (i == 65535) check("count_ffff", 32'(byte_count), 32'h0000FFFF);
    end
    check("count_wrap", 32'(byte_count), 32'd1);
    check("wrap_state", 32'(state), 32'(ST_ACTIVE));
    step(8'h00, 0, 0, ST_ACTIVE, 0, 1, 1'b1, "wrap_tail");
    check("sb_empty_wrap", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
